pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter IM_BYTES, default 1024, is the instruction memory size in bytes.
REQ-003 clk  input  1  single clock; all state updates on its posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  decode cannot accept; hold the presented instruction.
REQ-006 redirect  input  1  taken branch/jump; load redirect_target into PC.
REQ-007 redirect_target  input  32  byte address of the new fetch stream.
REQ-008 im_addr  output  32  fetch address to the instruction memory, equal to pc_q.
REQ-009 im_data  input  32  instruction memory read data, registered by memory one posedge after im_addr.
REQ-010 id_instr  output  32  instruction presented to decode.
REQ-011 id_pc  output  32  byte address of id_instr.
REQ-012 id_pc4  output  32  id_pc + 4, modulo 2^32.
REQ-013 id_valid  output  1  id_instr/id_pc are a real instruction.
REQ-014 addr_fault  output  1  sticky flag: PC misaligned or beyond IM_BYTES-4.

Function
REQ-015 The block SHALL keep pc_q (current fetch address) and f_pc_q/f_valid_q (address and validity of the in-flight memory read).
REQ-016 The block SHALL drive im_addr combinationally from pc_q.
REQ-017 States SHALL be FILL (first cycle after reset, nothing in flight), RUN, and HOLD.
REQ-018 FILL -> RUN unconditionally after one cycle; id_valid = 0 in FILL.
REQ-019 In RUN with no stall and no redirect, each posedge SHALL set pc_q <= pc_q+4, f_pc_q <= pc_q, f_valid_q <= 1.
REQ-020 In RUN, id_instr = im_data, id_pc = f_pc_q, id_valid = f_valid_q (one-cycle fetch latency).
REQ-021 RUN with stall=1 SHALL capture im_data into hold_instr, hold pc_q, f_pc_q, f_valid_q, and enter HOLD.
REQ-022 In HOLD, id_instr = hold_instr; the block SHALL hold all state until stall=0.
REQ-023 HOLD with stall=0 SHALL present hold_instr once more that cycle, then resume RUN; pc_q has stayed unchanged, so the memory re-reads pc_q during HOLD and the first cycle after HOLD needs no refetch.
REQ-024 redirect=1 SHALL override stall in any state: pc_q <= redirect_target, hold discarded, next state RUN.
REQ-025 On redirect, the in-flight slot SHALL be squashed (f_valid_q <= 0), except as given by REQ-032.
REQ-026 addr_fault SHALL set when pc_q[1:0] != 0 or pc_q > IM_BYTES-4; while set, id_valid = 0 and pc_q holds.
REQ-027 addr_fault SHALL clear only on reset or on a redirect to a valid target.
REQ-028 id_pc4 and PC increment SHALL wrap modulo 2^32; only addr_fault bounds the range.

Reset
REQ-029 While reset_n = 0: pc_q = RESET_PC, f_pc_q = 0, f_valid_q = 0, hold_instr = 0, state = FILL, addr_fault = 0.
REQ-030 In reset, outputs SHALL be: id_valid = 0, id_instr = 0, id_pc = 0, id_pc4 = 4, im_addr = RESET_PC.
REQ-031 Reset assertion mid-HOLD or mid-redirect SHALL discard all in-flight state immediately.

Configuration
REQ-032 With macro PC_FETCH_DELAY_SLOT_EN defined, the in-flight instruction at redirect (the delay slot) SHALL remain valid and be presented; when undefined, it SHALL be squashed per REQ-025.

Structure
REQ-033 The shared package SHALL hold the state enum (FILL/RUN/HOLD), the 32-bit word width, and the PC step constant 4.
REQ-034 All logic SHALL reside in pc_fetch with no sub-module; the next-PC mux may be a local function.

Verification
REQ-035 Reset release, RESET_PC=0, no stall -> im_addr 0,4,8,...; id_valid first 1 on the second cycle with id_pc=0, then id_pc=4.
REQ-036 stall high for 3 cycles while id_pc=8 -> id_instr/id_pc=8 stable all 3 cycles; after release, the next id_pc is 12 with no gap.
REQ-037 redirect to 0x40 while id_pc=0x10, macro undefined -> the instruction at 0x14 is squashed (id_valid 0 for one cycle), then id_pc=0x40.
REQ-038 Same stimulus as REQ-037 with PC_FETCH_DELAY_SLOT_EN defined -> id_pc 0x14 is presented with id_valid=1, followed by 0x40.
REQ-039 redirect to 0x3FE, then to 0x100 -> addr_fault=1 and id_valid=0 after the first redirect; after the second, addr_fault=0 and id_pc=0x100.
REQ-040 reset_n pulsed low during HOLD -> all outputs at reset values immediately; fetching restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the pc_fetch instruction-fetch stage.
package pc_fetch_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch.sv
// Single-stage instruction fetch with stall hold, redirect and sticky address fault.
// Optional macro PC_FETCH_DELAY_SLOT_EN keeps the in-flight instruction alive across a redirect.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_target,
  output logic [WORD_W-1:0] im_addr,
  input  logic [WORD_W-1:0] im_data,
  output logic [WORD_W-1:0] id_instr,
  output logic [WORD_W-1:0] id_pc,
  output logic [WORD_W-1:0] id_pc4,
  output logic              id_valid,
  output logic              addr_fault
);

  localparam logic [WORD_W-1:0] LAST_ADDR = WORD_W'(IM_BYTES - 32'd4);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] f_pc_q, f_pc_d;
  logic              f_valid_q, f_valid_d;
  logic [WORD_W-1:0] hold_instr_q, hold_instr_d;
  logic              addr_fault_q, addr_fault_d;
  logic              fault_s;

  function automatic logic pc_bad(input logic [WORD_W-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr > LAST_ADDR);
  endfunction

  // The flag is visible in the same cycle a bad PC appears, then stays sticky.
  assign fault_s = addr_fault_q | pc_bad(pc_q);
  assign im_addr = pc_q;

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_FILL;
      pc_q         <= RESET_PC;
      f_pc_q       <= 32'h0000_0000;
      f_valid_q    <= 1'b0;
      hold_instr_q <= 32'h0000_0000;
      addr_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      f_pc_q       <= f_pc_d;
      f_valid_q    <= f_valid_d;
      hold_instr_q <= hold_instr_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  // Next-state logic: redirect beats fault, fault beats stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    f_pc_d       = f_pc_q;
    f_valid_d    = f_valid_q;
    hold_instr_d = hold_instr_q;
    addr_fault_d = fault_s;
    if (redirect) begin
      state_d      = ST_RUN;
      pc_d         = redirect_target;
      f_pc_d       = pc_q;
`ifdef PC_FETCH_DELAY_SLOT_EN
      f_valid_d    = !fault_s;
`else
      f_valid_d    = 1'b0;
`endif
      hold_instr_d = 32'h0000_0000;
      addr_fault_d = pc_bad(redirect_target);
    end else if (fault_s) begin
      state_d   = ST_RUN;
      f_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          state_d   = ST_RUN;
          pc_d      = pc_q + PC_STEP;
          f_pc_d    = pc_q;
          f_valid_d = 1'b1;
        end
        ST_RUN: begin
          if (stall) begin
            state_d      = ST_HOLD;
            hold_instr_d = im_data;
          end else begin
            pc_d      = pc_q + PC_STEP;
            f_pc_d    = pc_q;
            f_valid_d = 1'b1;
          end
        end
        ST_HOLD: begin
          // Memory kept re-reading pc_q while held, so the next word is already on its way.
          if (stall) begin
            state_d = ST_HOLD;
          end else begin
            state_d   = ST_RUN;
            pc_d      = pc_q + PC_STEP;
            f_pc_d    = pc_q;
            f_valid_d = 1'b1;
          end
        end
        default: begin
          state_d   = ST_FILL;
          f_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Decode-side outputs.
  always_comb begin
    id_instr   = 32'h0000_0000;
    id_valid   = 1'b0;
    id_pc      = f_pc_q;
    id_pc4     = f_pc_q + PC_STEP;
    addr_fault = fault_s;
    case (state_q)
      ST_FILL: begin
        id_instr = 32'h0000_0000;
        id_valid = 1'b0;
      end
      ST_RUN: begin
        id_instr = im_data;
        id_valid = f_valid_q & ~fault_s;
      end
      ST_HOLD: begin
        id_instr = hold_instr_q;
        id_valid = f_valid_q & ~fault_s;
      end
      default: begin
        id_instr = 32'h0000_0000;
        id_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed vector table, reset-in-hold sequence, random run against a stream model.
module tb_pc_fetch;

`ifdef PC_FETCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] im_addr;
  logic [31:0] im_data = 32'h0;
  logic [31:0] id_instr, id_pc, id_pc4;
  logic        id_valid, addr_fault;

  logic [31:0] mem [256];
  int n_pass = 0;
  int n_total = 0;

  pc_fetch dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .im_addr(im_addr), .im_data(im_data),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid),
    .addr_fault(addr_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) im_data <= mem[im_addr[9:2]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  function automatic bit addr_is_bad(input logic [31:0] a);
    logic [32:0] top;
    top = {1'b0, a} + 33'd4;
    return (a % 32'd4 != 32'd0) || (top > 33'd1024);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, " id_instr"}, id_instr, 32'd0);
    check({tag, " id_pc"}, id_pc, 32'd0);
    check({tag, " id_pc4"}, id_pc4, 32'd4);
    check({tag, " im_addr"}, im_addr, 32'd0);
    check({tag, " addr_fault"}, {31'd0, addr_fault}, 32'd0);
  endtask

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  vec_t tbl [18];

  // Reference stream model state.
  bit          m_first, m_fault, p_valid;
  logic [31:0] m_nxt, p_pc;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // stall, redirect, target, im_addr, id_valid, id_pc, addr_fault
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   32'h000, 1'b0,       32'h000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   32'h004, 1'b1,       32'h000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   32'h008, 1'b1,       32'h004, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,   32'h00C, 1'b1,       32'h008, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,   32'h00C, 1'b1,       32'h008, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   32'h00C, 1'b1,       32'h008, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   32'h00C, 1'b1,       32'h008, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,   32'h010, 1'b1,       32'h00C, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 32'h40,  32'h014, 1'b1,       32'h010, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   32'h040, DELAY_SLOT, 32'h014, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   32'h044, 1'b1,       32'h040, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'h3FE, 32'h048, 1'b1,       32'h044, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   32'h3FE, 1'b0,       32'h000, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   32'h3FE, 1'b0,       32'h000, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 32'h100, 32'h3FE, 1'b0,       32'h000, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 32'h0,   32'h100, 1'b0,       32'h000, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 32'h0,   32'h104, 1'b1,       32'h100, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 32'h0,   32'h108, 1'b1,       32'h104, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_reset_outputs("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      stall = tbl[i].stall;
      redirect = tbl[i].redir;
      redirect_target = tbl[i].tgt;
      #1;
      check($sformatf("vec%0d im_addr", i), im_addr, tbl[i].e_addr);
      check($sformatf("vec%0d id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].e_valid});
      check($sformatf("vec%0d addr_fault", i), {31'd0, addr_fault}, {31'd0, tbl[i].e_fault});
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d id_pc", i), id_pc, tbl[i].e_pc);
        check($sformatf("vec%0d id_pc4", i), id_pc4, tbl[i].e_pc + 32'd4);
        check($sformatf("vec%0d id_instr", i), id_instr, mem_word(tbl[i].e_pc));
      end
      if (i == 0) check("fill id_instr", id_instr, 32'd0);
      @(negedge clk);
    end

    // Reset pulse while holding an instruction.
    stall = 1'b1;
    redirect = 1'b0;
    @(negedge clk);
    #1 check("hold id_pc", id_pc, 32'h108);
    check("hold id_instr", id_instr, mem_word(32'h108));
    reset_n = 1'b0;
    #1 check_reset_outputs("mid-hold reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    stall = 1'b0;
    #1 check("restart fill im_addr", im_addr, 32'h0);
    check("restart fill id_valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    #1 check("restart id_pc", id_pc, 32'h0);
    check("restart id_valid", {31'd0, id_valid}, 32'd1);
    check("restart im_addr", im_addr, 32'h4);

    // Random run against the stream model.
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_first = 1'b1;
    m_fault = 1'b0;
    p_valid = 1'b0;
    p_pc = 32'h0;
    m_nxt = 32'h0;
    for (int c = 0; c < 600; c++) begin
      bit fault_now, exp_v;
      stall = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 85) redirect_target = 32'($urandom_range(0, 255)) * 32'd4;
      else redirect_target = 32'h400 + 32'($urandom_range(0, 15));
      #1;
      fault_now = m_fault || addr_is_bad(m_nxt);
      exp_v = !m_first && p_valid && !fault_now;
      check("rnd im_addr", im_addr, m_nxt);
      check("rnd addr_fault", {31'd0, addr_fault}, {31'd0, fault_now});
      check("rnd id_valid", {31'd0, id_valid}, {31'd0, exp_v});
      if (exp_v) begin
        check("rnd id_pc", id_pc, p_pc);
        check("rnd id_pc4", id_pc4, p_pc + 32'd4);
        check("rnd id_instr", id_instr, mem_word(p_pc));
      end
      if (redirect) begin
        m_fault = addr_is_bad(redirect_target);
        p_valid = DELAY_SLOT && !fault_now;
        p_pc = m_nxt;
        m_nxt = redirect_target;
      end else if (fault_now) begin
        m_fault = 1'b1;
        p_valid = 1'b0;
      end else if (!(stall && !m_first)) begin
        p_valid = 1'b1;
        p_pc = m_nxt;
        m_nxt = m_nxt + 32'd4;
      end
      m_first = 1'b0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
